// File: rtl/voice_sine_scheduler_if.sv
// Signal bundle linking the note/config logic, the shared sine unit and the mix output path.
// The scheduler takes the slave side and the surrounding logic takes the master side.
interface voice_sine_scheduler_if #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int ANGLE_W    = 12,
    parameter int AMP_W      = 16,
    parameter int MIX_W      = AMP_W + $clog2(NUM_VOICES)
);
    localparam int VIDX_W = $clog2(NUM_VOICES);

    logic                      sample_tick;
    logic                      cfg_we;
    logic [VIDX_W-1:0]         cfg_voice;
    logic [PHASE_W-1:0]        cfg_inc;
    logic                      cfg_gate;
    logic [ANGLE_W-1:0]        sine_angle;
    logic [AMP_W-1:0]          sine_amp;
    logic signed [MIX_W-1:0]   mix_out;
    logic                      mix_valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_gate, sine_amp,
        input  sine_angle, mix_out, mix_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_gate, sine_amp,
        output sine_angle, mix_out, mix_valid, busy, overrun
    );
endinterface

// File: rtl/voice_sine_scheduler.sv
// Time-shares one pipelined sine unit between NUM_VOICES phase-accumulator voices and
// mixes the gated voices into one signed sample per audio tick.
module voice_sine_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int ANGLE_W    = 12,
    parameter int AMP_W      = 16,
    parameter int SINE_LAT   = 3,
    parameter int MIX_W      = AMP_W + $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    voice_sine_scheduler_if.slave bus
);
    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [VIDX_W-1:0]       r_idx;
    logic [ANGLE_W-1:0]      r_angle;
    logic [SINE_LAT-1:0]     r_ret_valid;
    logic [SINE_LAT-1:0]     r_ret_gate;
    logic signed [MIX_W-1:0] r_acc;
    logic signed [MIX_W-1:0] r_mix;
    logic                    r_overrun;

    logic [ANGLE_W-1:0]      w_voice_angle [NUM_VOICES];
    logic [NUM_VOICES-1:0]   w_voice_gate;
    logic                    w_issue;
    logic                    w_start;
    logic                    w_add;
    logic                    w_pipe_empty;
    logic                    w_mix_valid;
    logic                    w_busy;
    logic signed [AMP_W-1:0] w_amp_centered;
    logic signed [MIX_W-1:0] w_term;

    assign w_issue      = (r_state == S_ISSUE);
    assign w_start      = (r_state == S_IDLE) && bus.sample_tick;
    assign w_add        = r_ret_valid[SINE_LAT-1] && r_ret_gate[SINE_LAT-1];
    assign w_pipe_empty = ~|r_ret_valid;

    // Offset-binary to two's complement: flipping the MSB subtracts the midpoint.
    assign w_amp_centered = {~bus.sine_amp[AMP_W-1], bus.sine_amp[AMP_W-2:0]};
    assign w_term         = {{(MIX_W-AMP_W){w_amp_centered[AMP_W-1]}}, w_amp_centered};

    // Per-voice state; config writes and issue updates touch disjoint registers.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [PHASE_W-1:0] r_phase;
            logic [PHASE_W-1:0] r_inc;
            logic               r_gate;
            logic               w_sel_cfg;
            logic               w_sel_issue;

            assign w_sel_cfg   = bus.cfg_we && (bus.cfg_voice == VIDX_W'(gi));
            assign w_sel_issue = w_issue && (r_idx == VIDX_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_phase <= '0;
                    r_inc   <= '0;
                    r_gate  <= 1'b0;
                end else begin
                    if (w_sel_cfg) begin
                        r_inc  <= bus.cfg_inc;
                        r_gate <= bus.cfg_gate;
                    end
                    if (w_sel_issue) begin
                        r_phase <= r_gate ? (r_phase + r_inc) : '0;
                    end
                end
            end

            assign w_voice_angle[gi] = r_phase[PHASE_W-1 -: ANGLE_W];
            assign w_voice_gate[gi]  = r_gate;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.sample_tick)      w_state_next = S_ISSUE;
            S_ISSUE: if (r_idx == LAST_VOICE)  w_state_next = S_DRAIN;
            S_DRAIN: if (w_pipe_empty)         w_state_next = S_DONE;
            S_DONE:                            w_state_next = S_IDLE;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mix_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_ISSUE, S_DRAIN: w_busy = 1'b1;
            S_DONE: begin
                w_busy      = 1'b1;
                w_mix_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_angle     <= '0;
            r_ret_valid <= '0;
            r_ret_gate  <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= bus.sample_tick && w_busy;

            // Return tracker: entry i+1 is one edge older than entry i.
            for (int i = SINE_LAT - 1; i > 0; i--) begin
                r_ret_valid[i] <= r_ret_valid[i-1];
                r_ret_gate[i]  <= r_ret_gate[i-1];
            end
            r_ret_valid[0] <= w_issue;
            r_ret_gate[0]  <= w_issue && w_voice_gate[r_idx];

            if (w_issue) begin
                r_angle <= w_voice_angle[r_idx];
                r_idx   <= r_idx + VIDX_W'(1);
            end

            if (w_start) begin
                r_acc <= '0;
                r_idx <= '0;
            end else if (w_add) begin
                r_acc <= r_acc + w_term;
            end

            if ((r_state == S_DRAIN) && (w_state_next == S_DONE)) begin
                r_mix <= r_acc;
            end
        end
    end

    assign bus.sine_angle = r_angle;
    assign bus.mix_out    = r_mix;
    assign bus.mix_valid  = w_mix_valid;
    assign bus.busy       = w_busy;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_voice_sine_scheduler.sv
// Directed and randomized rounds against a per-voice phase/gate reference model,
// with a behavioural fixed-latency sine unit driving the amplitude input.
module tb_voice_sine_scheduler;
    localparam int NV  = 4;
    localparam int LAT = 3;
    localparam int ROUND_EDGES = NV + LAT + 1;

    logic clk;
    logic reset;

    voice_sine_scheduler_if #(.NUM_VOICES(NV), .PHASE_W(24), .ANGLE_W(12), .AMP_W(16)) bus ();

    voice_sine_scheduler #(
        .NUM_VOICES(NV), .PHASE_W(24), .ANGLE_W(12), .AMP_W(16), .SINE_LAT(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;
    int last_mix = 0;
    int rnd_tab [4096];

    logic [23:0] m_phase [NV];
    logic [23:0] m_inc   [NV];
    bit          m_gate  [NV];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sine_f(input int md, input logic [11:0] a);
        case (md)
            0:       return 32768 + int'(a);
            1:       return 65535;
            2:       return 0;
            default: return rnd_tab[a];
        endcase
    endfunction

    // Behavioural sine unit: amplitude for the angle shown after edge k is sampled at edge k+LAT.
    initial begin
        logic [11:0] hist [LAT];
        for (int i = 0; i < LAT; i++) hist[i] = '0;
        bus.sine_amp = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.sine_angle;
            bus.sine_amp = 16'(sine_f(mode, hist[LAT-1]));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = '0;
            m_inc[v]   = '0;
            m_gate[v]  = 1'b0;
        end
    endtask

    task automatic cfg_write(input int v, input logic [23:0] inc, input bit g);
        bus.cfg_we    = 1'b1;
        bus.cfg_voice = 2'(v);
        bus.cfg_inc   = inc;
        bus.cfg_gate  = g;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        m_inc[v]   = inc;
        m_gate[v]  = g;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_mix_valid", 32'(bus.mix_valid), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end
    endtask

    // One scheduling round. Optional extra tick sampled at edge tick2_edge, optional tick in the
    // DONE cycle, and an optional config write sampled at edge cfg_edge (all counted from E0).
    task automatic do_round(input int tick2_edge, input bit tick_done, input int cfg_edge,
                            input int cfg_v, input logic [23:0] cfg_i, input bit cfg_g);
        logic [11:0] ea [NV];
        int emix;
        emix = 0;
        for (int v = 0; v < NV; v++) begin
            ea[v] = m_phase[v][23:12];
            if (m_gate[v]) emix += sine_f(mode, ea[v]) - 32768;
        end
        bus.sample_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        check("busy_start", 32'(bus.busy), 32'd1);
        for (int j = 1; j <= ROUND_EDGES; j++) begin
            if (j == tick2_edge) bus.sample_tick = 1'b1;
            if (j == cfg_edge) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_voice = 2'(cfg_v);
                bus.cfg_inc   = cfg_i;
                bus.cfg_gate  = cfg_g;
            end
            @(posedge clk);
            #1;
            bus.sample_tick = 1'b0;
            bus.cfg_we      = 1'b0;
            if (j <= NV) check($sformatf("angle_v%0d", j - 1), 32'(bus.sine_angle), 32'(ea[j-1]));
            check($sformatf("mix_valid_e%0d", j), 32'(bus.mix_valid), 32'(j == ROUND_EDGES));
            check($sformatf("overrun_e%0d", j), 32'(bus.overrun), 32'(j == tick2_edge));
            check($sformatf("busy_e%0d", j), 32'(bus.busy), 32'd1);
        end
        last_mix = int'(bus.mix_out);
        check("mix_out", 32'(last_mix), 32'(emix));
        if (tick_done) bus.sample_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        check("busy_end", 32'(bus.busy), 32'd0);
        check("mix_valid_end", 32'(bus.mix_valid), 32'd0);
        check("overrun_done", 32'(bus.overrun), 32'(tick_done));
        check("mix_hold", 32'(int'(bus.mix_out)), 32'(emix));
        for (int v = 0; v < NV; v++)
            m_phase[v] = m_gate[v] ? (m_phase[v] + m_inc[v]) : 24'h0;
        if (cfg_edge > 0) begin
            m_inc[cfg_v]  = cfg_i;
            m_gate[cfg_v] = cfg_g;
        end
        $display("round: mix_out=%0d expected=%0d mode=%0d", last_mix, emix, mode);
    endtask

    initial begin
        reset           = 1'b1;
        bus.sample_tick = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_voice   = '0;
        bus.cfg_inc     = '0;
        bus.cfg_gate    = 1'b0;
        for (int i = 0; i < 4096; i++) rnd_tab[i] = int'($urandom_range(0, 65535));
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and quiet idle
        check("rst_mix_out", 32'(int'(bus.mix_out)), 32'd0);
        check("rst_angle", 32'(bus.sine_angle), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        idle_check(20);
        check("idle_angle", 32'(bus.sine_angle), 32'd0);

        // All gates off
        mode = 0;
        do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);
        check("gates_off_mix", 32'(last_mix), 32'd0);

        // Single voice ramp, wrapping after 16 rounds
        cfg_write(0, 24'h100000, 1'b1);
        for (int r = 0; r < 17; r++) begin
            do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);
            if (r == 1) check("ramp_r2", 32'(last_mix), 32'd256);
            if (r == 2) check("ramp_r3", 32'(last_mix), 32'd512);
        end
        check("ramp_wrap", 32'(last_mix), 32'd0);

        // Full scale, all voices gated
        cfg_write(1, 24'h012345, 1'b1);
        cfg_write(2, 24'h0ABCDE, 1'b1);
        cfg_write(3, 24'h333333, 1'b1);
        mode = 1;
        do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);
        check("full_pos", 32'(last_mix), 32'd131068);
        mode = 2;
        do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);
        check("full_neg", 32'(last_mix), 32'hFFFE_0000);

        // Overruns mid-round and in the DONE cycle; no extra round may follow
        mode = 0;
        do_round(2, 1'b1, -1, 0, 24'h0, 1'b0);
        idle_check(12);

        // Config write colliding with voice 2's issue edge, then gate-off the same way
        do_round(-1, 1'b0, 3, 2, 24'h0A0000, 1'b1);
        do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);
        do_round(-1, 1'b0, 3, 2, 24'h050000, 1'b0);
        do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);
        do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);

        // Randomized configs and amplitudes
        mode = 3;
        for (int r = 0; r < 12; r++) begin
            cfg_write(int'($urandom_range(0, NV - 1)), 24'($urandom), ($urandom_range(0, 3) != 0));
            do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);
        end

        // Reset sampled at E3 aborts the round and clears every phase
        bus.sample_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_mix_valid", 32'(bus.mix_valid), 32'd0);
        check("abort_angle", 32'(bus.sine_angle), 32'd0);
        check("abort_mix_out", 32'(int'(bus.mix_out)), 32'd0);
        model_reset();
        idle_check(12);
        for (int v = 0; v < NV; v++) cfg_write(v, 24'($urandom), 1'b1);
        do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);
        do_round(-1, 1'b0, -1, 0, 24'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
